// File: rtl/execute_muldiv.sv
// Execute stage: single-cycle ALU, EX/MEM output register and HI/LO interlock.
// Define MULDIV_EN to build the iterative 32-cycle multiply/divide unit with HI/LO registers.
module execute_muldiv #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm,
    input  logic [4:0]         i_shamt,
    input  logic [3:0]         i_alu_ctrl,
    input  logic               i_aluSrc,
    input  logic [1:0]         i_hilo_sel,
    input  logic [NB_REG-1:0]  i_write_reg,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_DATA-1:0] o_data4Mem,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic [1:0]         o_width,
    output logic               o_sign_flag,
    output logic               o_mem2reg,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_regWrite,
    output logic               o_stall,
    output logic               o_busy
);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_NOR = 4'd5,  OP_SLT = 4'd6,  OP_SLTU = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_LUI  = 4'd11;

    logic [NB_DATA-1:0] alu_b, alu_res, hi_val, lo_val;
    logic               md_op, hilo_rd, busy, stall, md_bubble;

    assign alu_b   = i_aluSrc ? i_imm : i_rt_data;
    assign md_op   = (i_alu_ctrl[3:2] == 2'b11);
    assign hilo_rd = (i_hilo_sel == 2'b01) || (i_hilo_sel == 2'b10);

    always_comb begin
        alu_res = '0;
        case (i_alu_ctrl)
            OP_ADD:  alu_res = i_rs_data + alu_b;
            OP_SUB:  alu_res = i_rs_data - alu_b;
            OP_AND:  alu_res = i_rs_data & alu_b;
            OP_OR:   alu_res = i_rs_data | alu_b;
            OP_XOR:  alu_res = i_rs_data ^ alu_b;
            OP_NOR:  alu_res = ~(i_rs_data | alu_b);
            OP_SLT:  alu_res = {{(NB_DATA-1){1'b0}}, ($signed(i_rs_data) < $signed(alu_b))};
            OP_SLTU: alu_res = {{(NB_DATA-1){1'b0}}, (i_rs_data < alu_b)};
            OP_SLL:  alu_res = i_rt_data << i_shamt;
            OP_SRL:  alu_res = i_rt_data >> i_shamt;
            OP_SRA:  alu_res = $signed(i_rt_data) >>> i_shamt;
            OP_LUI:  alu_res = {i_imm[15:0], {(NB_DATA-16){1'b0}}};
            default: alu_res = '0;
        endcase
    end

`ifdef MULDIV_EN
    // state   | meaning
    // IDLE    | unit free, accepts ops 12-15 ; BUSY | one shift-add / restoring step per clock
    typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;
    localparam int NB_CNT = $clog2(NB_DATA);

    md_state_e            state_q, state_d;
    logic [NB_CNT-1:0]    cnt_q, cnt_d;
    logic [2*NB_DATA-1:0] acc_q, acc_d, acc_next, prod;
    logic [NB_DATA-1:0]   opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic                 is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d, div0_q, div0_d;
    logic                 md_signed, rs_neg, rt_neg, div_ge;
    logic [NB_DATA-1:0]   rs_mag, rt_mag, quot, rem, div_diff;
    logic [NB_DATA:0]     mul_sum, div_shift;

    assign md_signed = ~i_alu_ctrl[0];
    assign rs_neg    = md_signed & i_rs_data[NB_DATA-1];
    assign rt_neg    = md_signed & i_rt_data[NB_DATA-1];
    assign rs_mag    = rs_neg ? -i_rs_data : i_rs_data;
    assign rt_mag    = rt_neg ? -i_rt_data : i_rt_data;

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + {1'b0, opb_q};
    assign div_shift = acc_q[2*NB_DATA-1:NB_DATA-1];
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_diff  = div_shift[NB_DATA-1:0] - opb_q;
    assign acc_next  = is_div_q ?
                       {(div_ge ? div_diff : div_shift[NB_DATA-1:0]), acc_q[NB_DATA-2:0], div_ge} :
                       (acc_q[0] ? {mul_sum, acc_q[NB_DATA-1:1]} : {1'b0, acc_q[2*NB_DATA-1:1]});
    assign prod      = neg_q ? -acc_next : acc_next;
    assign quot      = acc_next[NB_DATA-1:0];
    assign rem       = acc_next[2*NB_DATA-1:NB_DATA];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        case (state_q)
            ST_IDLE: begin
                if (md_op) begin
                    state_d   = ST_BUSY;
                    cnt_d     = '1;
                    is_div_d  = i_alu_ctrl[1];
                    acc_d     = {{NB_DATA{1'b0}}, rs_mag};
                    opb_d     = rt_mag;
                    neg_d     = rs_neg ^ rt_neg;
                    rem_neg_d = rs_neg;
                    div0_d    = (i_rt_data == '0);
                end
            end
            ST_BUSY: begin
                acc_d = acc_next;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (is_div_q) begin
                        lo_d = div0_q ? '1 : (neg_q ? -quot : quot);
                        hi_d = rem_neg_q ? -rem : rem;
                    end else begin
                        hi_d = prod[2*NB_DATA-1:NB_DATA];
                        lo_d = prod[NB_DATA-1:0];
                    end
                end else begin
                    cnt_d = cnt_q - NB_CNT'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else if (!i_halt) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign hi_val    = hi_q;
    assign lo_val    = lo_q;
    assign md_bubble = 1'b0;
`else
    assign busy      = 1'b0;
    assign hi_val    = '0;
    assign lo_val    = '0;
    assign md_bubble = md_op;
`endif

    assign stall   = busy & (md_op | hilo_rd);
    assign o_stall = stall;
    assign o_busy  = busy;

    logic [NB_DATA-1:0] result_q, result_d, data4mem_q, data4mem_d;
    logic [NB_REG-1:0]  write_reg_q, write_reg_d;
    logic [1:0]         width_q, width_d;
    logic               sign_flag_q, sign_flag_d, mem2reg_q, mem2reg_d;
    logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d, reg_write_q, reg_write_d;

    always_comb begin
        result_d    = result_q;
        data4mem_d  = data4mem_q;
        write_reg_d = '0;
        width_d     = '0;
        sign_flag_d = 1'b0;
        mem2reg_d   = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        reg_write_d = 1'b0;
        if (!stall) begin
            result_d   = (i_hilo_sel == 2'b01) ? hi_val :
                         (i_hilo_sel == 2'b10) ? lo_val : alu_res;
            data4mem_d = i_rt_data;
            if (!md_bubble) begin
                write_reg_d = i_write_reg;
                width_d     = i_width;
                sign_flag_d = i_sign_flag;
                mem2reg_d   = i_mem2reg;
                mem_read_d  = i_memRead & ~md_op;
                mem_write_d = i_memWrite & ~md_op;
                reg_write_d = i_regWrite & ~md_op;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            result_q    <= '0;
            data4mem_q  <= '0;
            write_reg_q <= '0;
            width_q     <= '0;
            sign_flag_q <= 1'b0;
            mem2reg_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (!i_halt) begin
            result_q    <= result_d;
            data4mem_q  <= data4mem_d;
            write_reg_q <= write_reg_d;
            width_q     <= width_d;
            sign_flag_q <= sign_flag_d;
            mem2reg_q   <= mem2reg_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign o_result    = result_q;
    assign o_data4Mem  = data4mem_q;
    assign o_write_reg = write_reg_q;
    assign o_width     = width_q;
    assign o_sign_flag = sign_flag_q;
    assign o_mem2reg   = mem2reg_q;
    assign o_memRead   = mem_read_q;
    assign o_memWrite  = mem_write_q;
    assign o_regWrite  = reg_write_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed and random steps checked against an arithmetic reference model.
module tb_execute_muldiv;
`ifdef MULDIV_EN
    localparam bit MDEN = 1'b1;
`else
    localparam bit MDEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, halt, alu_src, sign_flag, mem2reg, mem_read, mem_write, reg_write;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt, write_reg;
    logic [3:0]  alu_ctrl;
    logic [1:0]  hilo_sel, width;
    logic [31:0] o_result, o_data4Mem;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_width;
    logic        o_sign_flag, o_mem2reg, o_memRead, o_memWrite, o_regWrite, o_stall, o_busy;

    always #5 clk = ~clk;

    execute_muldiv dut (
        .clk(clk), .i_rst_n(rst_n), .i_halt(halt),
        .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm), .i_shamt(shamt),
        .i_alu_ctrl(alu_ctrl), .i_aluSrc(alu_src), .i_hilo_sel(hilo_sel),
        .i_write_reg(write_reg), .i_width(width), .i_sign_flag(sign_flag),
        .i_mem2reg(mem2reg), .i_memRead(mem_read), .i_memWrite(mem_write), .i_regWrite(reg_write),
        .o_result(o_result), .o_data4Mem(o_data4Mem), .o_write_reg(o_write_reg),
        .o_width(o_width), .o_sign_flag(o_sign_flag), .o_mem2reg(o_mem2reg),
        .o_memRead(o_memRead), .o_memWrite(o_memWrite), .o_regWrite(o_regWrite),
        .o_stall(o_stall), .o_busy(o_busy)
    );

    int tests = 0, fails = 0, stall_seen = 0, s0;

    // reference state: architectural HI/LO, pending result and busy edges left
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [63:0] m_pend = 0;
    int          m_left = 0;
    logic [31:0] e_result = 0, e_data = 0;
    logic [4:0]  e_wr = 0;
    logic [1:0]  e_width = 0;
    logic        e_sign = 0, e_m2r = 0, e_mr = 0, e_mw = 0, e_rw = 0, e_chk = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, rt, im,
                                            input logic [4:0] sh, input logic src);
        logic [31:0] b;
        b = src ? im : rt;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return rt << sh;
            4'd9:  return rt >> sh;
            4'd10: return 32'($signed(rt) >>> sh);
            4'd11: return {im[15:0], 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    // returns {HI, LO}
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, b);
        longint sa, sb;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd12: return 64'(sa * sb);
            4'd13: return {32'h0, a} * {32'h0, b};
            4'd14: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = 32'(sa / sb);
                r = 32'(sa % sb);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, rt, input logic [1:0] hsel);
        alu_ctrl = op; rs_data = rs; rt_data = rt; hilo_sel = hsel;
        imm = $urandom; shamt = 5'($urandom); alu_src = 1'($urandom);
        write_reg = 5'($urandom); width = 2'($urandom); sign_flag = 1'($urandom);
        mem2reg = 1'($urandom); mem_read = 1'($urandom); mem_write = 1'($urandom);
        reg_write = 1'($urandom);
    endtask

    task automatic cycle();
        logic md, hrd, st;
        md  = (alu_ctrl >= 4'd12);
        hrd = (hilo_sel == 2'b01) || (hilo_sel == 2'b10);
        st  = MDEN && (m_left > 0) && (md || hrd);
        #1;
        chk("stall", o_stall, st);
        if (o_stall === 1'b1) stall_seen++;
        if (!rst_n) begin
            m_hi = 0; m_lo = 0; m_left = 0;
            e_result = 0; e_data = 0; e_wr = 0; e_width = 0;
            e_sign = 0; e_m2r = 0; e_mr = 0; e_mw = 0; e_rw = 0; e_chk = 1;
        end else if (!halt) begin
            if (st || (!MDEN && md)) begin
                e_wr = 0; e_width = 0; e_sign = 0; e_m2r = 0; e_mr = 0; e_mw = 0; e_rw = 0;
                if (!st) e_chk = 0;
            end else begin
                e_chk    = !md;
                e_result = !hrd ? ref_alu(alu_ctrl, rs_data, rt_data, imm, shamt, alu_src) :
                           !MDEN ? 32'h0 : (hilo_sel == 2'b01 ? m_hi : m_lo);
                e_data   = rt_data;
                e_wr = write_reg; e_width = width; e_sign = sign_flag; e_m2r = mem2reg;
                e_mr = mem_read & !md; e_mw = mem_write & !md; e_rw = reg_write & !md;
            end
            if (MDEN) begin
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) {m_hi, m_lo} = m_pend;
                end else if (md) begin
                    m_left = 32;
                    m_pend = ref_md(alu_ctrl, rs_data, rt_data);
                end
            end
        end
        @(posedge clk);
        #1;
        if (e_chk) begin
            chk("result", o_result, e_result);
            chk("data4mem", o_data4Mem, e_data);
        end
        chk("write_reg", o_write_reg, e_wr);
        chk("width", o_width, e_width);
        chk("sign_flag", o_sign_flag, e_sign);
        chk("mem2reg", o_mem2reg, e_m2r);
        chk("memRead", o_memRead, e_mr);
        chk("memWrite", o_memWrite, e_mw);
        chk("regWrite", o_regWrite, e_rw);
        chk("busy", o_busy, m_left > 0);
    endtask

    // present an HI/LO read and hold it until the model says the unit is free, then issue it
    task automatic read_hilo(input logic [1:0] hsel);
        drive(4'd0, $urandom, $urandom, hsel);
        for (int g = 0; g < 60 && m_left > 0; g++) cycle();
        cycle();
    endtask

    task automatic indep();
        drive(4'($urandom_range(0, 11)), $urandom, $urandom, $urandom_range(0, 1) ? 2'b00 : 2'b11);
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; halt = 1'b0;
        drive(4'd0, 0, 0, 2'b00);
        @(posedge clk); #1;
        repeat (2) cycle();
        chk("reset_result", o_result, 0);
        chk("reset_busy", o_busy, 0);
        rst_n = 1'b1;

        drive(4'd0, 32'h7FFFFFFF, 32'h1, 2'b00);
        alu_src = 1'b0; write_reg = 5'd3; reg_write = 1'b1;
        cycle();
        chk("add_wrap", o_result, 32'h80000000);
        chk("add_wreg", o_write_reg, 3);
        chk("add_rw", o_regWrite, 1);

        for (int i = 0; i < 80; i++) begin
            drive(4'($urandom_range(0, 11)), $urandom, $urandom, 2'($urandom));
            cycle();
        end

        drive(4'd12, 32'hFFFFFFFD, 32'd7, 2'b00);
        cycle();
        s0 = stall_seen;
        read_hilo(2'b10);
        chk("mult_stalls", stall_seen - s0, MDEN ? 32 : 0);
        chk("mult_lo", o_result, MDEN ? 32'hFFFFFFEB : 32'h0);
        read_hilo(2'b01);
        chk("mult_hi", o_result, MDEN ? 32'hFFFFFFFF : 32'h0);

        drive(4'd15, 32'd100, 32'd7, 2'b00);
        cycle();
        s0 = stall_seen;
        repeat (10) begin drive(4'd0, $urandom, $urandom, 2'b00); cycle(); end
        chk("divu_add_nostall", stall_seen - s0, 0);
        read_hilo(2'b01);
        chk("divu_stalls", stall_seen - s0, MDEN ? 22 : 0);
        chk("divu_hi", o_result, MDEN ? 32'd2 : 32'h0);
        read_hilo(2'b10);
        chk("divu_lo", o_result, MDEN ? 32'd14 : 32'h0);

        drive(4'd14, 32'd5, 32'd0, 2'b00);
        cycle();
        read_hilo(2'b10);
        chk("div0_lo", o_result, MDEN ? 32'hFFFFFFFF : 32'h0);
        read_hilo(2'b01);
        chk("div0_hi", o_result, MDEN ? 32'd5 : 32'h0);
        drive(4'd14, 32'h80000000, 32'hFFFFFFFF, 2'b00);
        cycle();
        read_hilo(2'b10);
        chk("divovf_lo", o_result, MDEN ? 32'h80000000 : 32'h0);
        read_hilo(2'b01);
        chk("divovf_hi", o_result, 0);

        drive(4'd13, $urandom, $urandom | 32'h1, 2'b00);
        cycle();
        repeat (10) indep();
        rst_n = 1'b0; halt = 1'b1;
        indep();
        chk("rst_busy", o_busy, 0);
        rst_n = 1'b1; halt = 1'b0;
        s0 = stall_seen;
        read_hilo(2'b01);
        chk("rst_nostall", stall_seen - s0, 0);
        chk("rst_hi", o_result, 0);

        drive(4'd12, $urandom, $urandom, 2'b00);
        cycle();
        s0 = stall_seen;
        drive(4'd0, $urandom, $urandom, 2'b10);
        repeat (4) cycle();
        halt = 1'b1;
        repeat (5) cycle();
        halt = 1'b0;
        for (int g = 0; g < 60 && m_left > 0; g++) cycle();
        cycle();
        chk("halt_stalls", stall_seen - s0, MDEN ? 37 : 0);
        read_hilo(2'b01);

        for (int i = 0; i < 14; i++) begin
            logic [31:0] b;
            b = (i % 5 == 0) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom);
            drive(4'($urandom_range(12, 15)), $urandom, b, 2'b00);
            cycle();
            repeat ($urandom_range(0, 40)) begin
                drive(4'($urandom), $urandom, $urandom, 2'($urandom));
                halt = ($urandom_range(0, 9) == 0);
                cycle();
            end
            halt = 1'b0;
            read_hilo(2'b01);
            read_hilo(2'b10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
